// File: rtl/alu_seq.sv
// alu_seq: handshaked, registered ALU with an iterative shift-add multiplier.
// One operation in flight: IDLE accepts, MUL iterates one multiplier bit per
// edge, DONE holds the result until the consumer takes it.
// Build option: define ALU_SEQ_FAST_MUL_EN to replace the iterative multiplier
// with a single-cycle combinational one (no MUL state, busy tied low).
module alu_seq #(
    parameter int WIDTH     = 24,
    parameter int LUI_SHIFT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             z,
    output logic             c,
    output logic             busy
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_MUL  = 3'b001;
    localparam logic [2:0] OP_PASS = 3'b010;
    localparam logic [2:0] OP_ADDR = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_LUI  = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_AND  = 3'b111;

`ifdef ALU_SEQ_FAST_MUL_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DONE = 2'd2} state_t;
    localparam int CW = $clog2(WIDTH + 1);
`endif

    state_t           state_q;
    logic [WIDTH-1:0] y_q;
    logic             z_q;
    logic             c_q;

    logic [WIDTH:0]   sum_d;
    logic [WIDTH-1:0] alu_y_d;
    logic             alu_c_d;

`ifndef ALU_SEQ_FAST_MUL_EN
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [CW-1:0]    cnt_q;
`endif

    // Single-cycle result and carry for every op that completes at accept.
    always_comb begin
        sum_d   = {1'b0, a} + {1'b0, b};
        alu_y_d = '0;
        alu_c_d = 1'b0;
        case (alu_op)
            OP_ADD, OP_ADDR: begin
                alu_y_d = sum_d[WIDTH-1:0];
                alu_c_d = sum_d[WIDTH];
            end
`ifdef ALU_SEQ_FAST_MUL_EN
            OP_MUL:  alu_y_d = a * b;  // context width WIDTH keeps the low half
`endif
            OP_PASS: alu_y_d = b;
            OP_OR:   alu_y_d = a | b;
            OP_LUI:  alu_y_d = b << LUI_SHIFT;
            OP_SUB: begin
                alu_y_d = a - b;
                alu_c_d = (a < b);
            end
            OP_AND:  alu_y_d = a & b;
            default: alu_y_d = '0;
        endcase
    end

`ifndef ALU_SEQ_FAST_MUL_EN
    // Accumulator after this edge's partial product.
    always_comb begin
        acc_d = acc_q;
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
    end
`endif

    // Control FSM and result registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            y_q      <= '0;
            z_q      <= 1'b1;
            c_q      <= 1'b0;
`ifndef ALU_SEQ_FAST_MUL_EN
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
`ifndef ALU_SEQ_FAST_MUL_EN
                        if (alu_op == OP_MUL) begin
                            mcand_q  <= a;
                            mplier_q <= b;
                            acc_q    <= '0;
                            cnt_q    <= CW'(WIDTH);
                            state_q  <= S_MUL;
                        end else
`endif
                        begin
                            y_q     <= alu_y_d;
                            z_q     <= (alu_y_d == '0);
                            c_q     <= alu_c_d;
                            state_q <= S_DONE;
                        end
                    end
                end
`ifndef ALU_SEQ_FAST_MUL_EN
                S_MUL: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        y_q     <= acc_d;
                        z_q     <= (acc_d == '0);
                        c_q     <= 1'b0;
                        state_q <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    if (out_ready) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign y         = y_q;
    assign z         = z_q;
    assign c         = c_q;
`ifdef ALU_SEQ_FAST_MUL_EN
    assign busy      = 1'b0;
`else
    assign busy      = (state_q == S_MUL);
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases plus random ops against an
// arithmetic reference model.
module tb_alu_seq;

    localparam int W  = 24;
    localparam int LS = 8;
`ifdef ALU_SEQ_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [2:0]   alu_op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready, out_valid, z, c, busy;
    logic [W-1:0] y;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W), .LUI_SHIFT(LS)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .a(a), .b(b), .out_valid(out_valid),
        .out_ready(out_ready), .y(y), .z(z), .c(c), .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: {carry, result} from plain unsigned arithmetic.
    function automatic logic [W:0] model(input logic [2:0] op, input logic [W-1:0] x,
                                         input logic [W-1:0] v);
        longint unsigned m  = (64'd1 << W) - 64'd1;
        longint unsigned xa = 64'(x);
        longint unsigned vb = 64'(v);
        longint unsigned r  = 0;
        logic cf = 1'b0;
        case (op)
            3'd0, 3'd3: begin r = xa + vb; cf = r[W]; end
            3'd1: r = xa * vb;
            3'd2: r = vb;
            3'd4: r = xa | vb;
            3'd5: r = vb << LS;
            3'd6: begin r = xa - vb; cf = (xa < vb); end
            default: r = xa & vb;
        endcase
        return {cf, W'(r & m)};
    endfunction

    // Issue one op, measure latency/busy, check result, apply `hold` cycles of
    // backpressure with junk inputs, then drain.
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] aa, input logic [W-1:0] bb,
                          input int hold, input string tag);
        logic [W:0] e;
        int cyc, bcnt, exp_cyc, exp_busy;
        bit is_mul;
        e        = model(op, aa, bb);
        is_mul   = (op == 3'b001);
        // Sample 1 is the cycle right after the accept edge; an iterative MUL
        // spends W cycles busy, so its result appears at sample W+1.
        exp_cyc  = (is_mul && !FAST) ? W + 1 : 1;
        exp_busy = (is_mul && !FAST) ? W : 0;
        @(negedge clk);
        chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1; alu_op = op; a = aa; b = bb;
        @(negedge clk);
        in_valid = 1'b0; alu_op = 3'($urandom); a = W'($urandom); b = W'($urandom);
        cyc = 1; bcnt = 0;
        while (!out_valid && cyc < 200) begin
            if (busy) bcnt++;
            @(negedge clk);
            cyc++;
        end
        chk({tag, " out_valid"}, 64'(out_valid), 64'd1);
        chk({tag, " latency"}, 64'(cyc), 64'(exp_cyc));
        chk({tag, " busy_cycles"}, 64'(bcnt), 64'(exp_busy));
        chk({tag, " y"}, 64'(y), 64'(e[W-1:0]));
        chk({tag, " z"}, 64'(z), 64'(e[W-1:0] == '0));
        chk({tag, " c"}, 64'(c), 64'(e[W]));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; alu_op = 3'($urandom); a = W'($urandom); b = W'($urandom);
            @(negedge clk);
            chk({tag, " hold y"}, 64'(y), 64'(e[W-1:0]));
            chk({tag, " hold in_ready"}, 64'(in_ready), 64'd0);
            chk({tag, " hold out_valid"}, 64'(out_valid), 64'd1);
        end
        // in_valid stays high across the draining edge: must not be taken in DONE.
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        chk({tag, " drained out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, " drained in_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("reset in_ready", 64'(in_ready), 64'd1);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset y", 64'(y), 64'd0);
        chk("reset z", 64'(z), 64'd1);
        chk("reset c", 64'(c), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        rst = 1'b0;

        run_op(3'b000, 24'hFFFFFF, 24'h000001, 0, "add_wrap");
        chk("add_wrap y const", 64'(y), 64'h0);
        run_op(3'b001, 24'd5, 24'd7, 0, "mul_5x7");
        chk("mul_5x7 y const", 64'(y), 64'h23);
        run_op(3'b001, 24'h001000, 24'h001000, 0, "mul_trunc");
        chk("mul_trunc z const", 64'(z), 64'd1);
        run_op(3'b110, 24'd3, 24'd5, 0, "sub_borrow");
        chk("sub_borrow y const", 64'(y), 64'hFFFFFE);
        run_op(3'b101, 24'h000000, 24'h0000AB, 0, "lui");
        chk("lui y const", 64'(y), 64'h00AB00);
        run_op(3'b100, 24'hF0F0F0, 24'h0F0F0F, 10, "or_bp");
        chk("or_bp y const", 64'(y), 64'hFFFFFF);

        // Reset in the 10th cycle of a MUL aborts it.
        @(negedge clk);
        in_valid = 1'b1; alu_op = 3'b001; a = 24'h123456; b = 24'h00FFFF;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort in_ready", 64'(in_ready), 64'd1);
        chk("abort out_valid", 64'(out_valid), 64'd0);
        chk("abort y", 64'(y), 64'd0);
        chk("abort z", 64'(z), 64'd1);
        chk("abort busy", 64'(busy), 64'd0);
        run_op(3'b000, 24'd2, 24'd2, 0, "add_after_abort");
        chk("add_after_abort y const", 64'(y), 64'd4);

        for (int k = 0; k < 40; k++) begin
            logic [2:0] op;
            logic [W-1:0] ra, rb;
            op = 3'($urandom);
            ra = W'($urandom);
            rb = W'($urandom);
            if (k % 5 == 0) rb = ra;            // exercise z and the a==b SUB edge
            run_op(op, ra, rb, int'($urandom_range(0, 3)), $sformatf("rnd%0d_op%0d", k, op));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
